// File: rtl/circuito_exp6_desafio_pkg.sv
// Shared definitions for the Genius memory-sequence game: data width,
// state encodings shown on the hex debug display, and the power-up
// image of the sequence memory.
package circuito_exp6_desafio_pkg;

    localparam int data_w    = 4;
    localparam int mem_depth = 16;

    typedef logic [data_w-1:0] word_t;

    // Encodings are chosen so the hex digit on db_estado names the state.
    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_espera         = 4'h2,
        st_registra       = 4'h3,
        st_compara        = 4'h4,
        st_proximo        = 4'h5,
        st_espera_nova    = 4'h6,
        st_escreve        = 4'h7,
        st_proxima_rodada = 4'h8,
        st_fim_ganhou     = 4'hC,
        st_fim_perdeu     = 4'hD,
        st_fim_timeout    = 4'hE
    } estado_t;

    // First move of every game is fixed at address 0; the rest start empty.
    localparam word_t mem_init [mem_depth] = '{0: 4'b0001, default: 4'b0000};

    // Game-over states: results are held until reset or a new start.
    function automatic logic estado_final(input estado_t s);
        return (s == st_fim_ganhou) || (s == st_fim_perdeu) || (s == st_fim_timeout);
    endfunction

    // States in which the player is expected to press a button.
    function automatic logic estado_aguarda(input estado_t s);
        return (s == st_espera) || (s == st_espera_nova);
    endfunction

endpackage

// File: rtl/circuito_exp6_desafio_hexa7seg.sv
// 4-bit to active-low 7-segment decoder. Output bit order is
// {g, f, e, d, c, b, a}; a 0 lights the segment.
module circuito_exp6_desafio_hexa7seg (
    input  logic [3:0] valor,
    output logic [6:0] segmentos
);

    // Pure lookup of the hexadecimal glyph for the input nibble.
    always_comb begin
        segmentos = 7'b1111111;
        case (valor)
            4'h0: segmentos = 7'b1000000;
            4'h1: segmentos = 7'b1111001;
            4'h2: segmentos = 7'b0100100;
            4'h3: segmentos = 7'b0110000;
            4'h4: segmentos = 7'b0011001;
            4'h5: segmentos = 7'b0010010;
            4'h6: segmentos = 7'b0000010;
            4'h7: segmentos = 7'b1111000;
            4'h8: segmentos = 7'b0000000;
            4'h9: segmentos = 7'b0010000;
            4'hA: segmentos = 7'b0001000;
            4'hB: segmentos = 7'b0000011;
            4'hC: segmentos = 7'b1000110;
            4'hD: segmentos = 7'b0100001;
            4'hE: segmentos = 7'b0000110;
            4'hF: segmentos = 7'b0001110;
            default: segmentos = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_exp6_desafio.sv
// Top level of the Genius challenge game. The player repeats the stored
// sequence; after each complete round one new move is appended to memory.
// Optional press timeout: define CIRCUITO_EXP6_TIMEOUT_EN to build the
// timer and make fim_timeout reachable; otherwise the game waits forever.
module circuito_exp6_desafio
    import circuito_exp6_desafio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int N_ROUNDS       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_igual,
    output logic       db_enderecoIgualRodada,
    output logic       db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_rodada,
    output logic [6:0] db_estado
);

    localparam logic [3:0] ultima_rodada = 4'(N_ROUNDS - 1);

    estado_t estado;
    estado_t proximo_estado;

    // Datapath registers
    logic [3:0] end_e;
    logic [3:0] rodada;
    word_t      jogada_reg;
    logic       tem_jogada;
    logic       tem_jogada_d;
    logic       jogada;

    // Memory
    word_t mem [mem_depth];
    word_t mem_dado;

    // Comparisons
    logic igual;
    logic end_igual_rodada;
    logic fim_sequencia;
    logic ativo;
    logic timeout;

    // Control strobes from the output decoder
    logic zera_tudo;
    logic conta_e;
    logic avanca_rodada;
    logic carrega_jogada;
    logic escreve_mem;
    logic zera_timeout;

    // ------------------------------------------------------------------
    // Press detection: one-cycle pulse on the rising edge of any button.
    // ------------------------------------------------------------------
    assign tem_jogada = |botoes;
    assign jogada     = tem_jogada && !tem_jogada_d;

    // Delayed copy of the button activity for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) tem_jogada_d <= 1'b0;
        else        tem_jogada_d <= tem_jogada;
    end

    // ------------------------------------------------------------------
    // Counters and move register.
    // ------------------------------------------------------------------
    // Address counter E: cleared on start and on each new round.
    always_ff @(posedge clock) begin
        if (!reset || zera_tudo || avanca_rodada) end_e <= 4'd0;
        else if (conta_e)                         end_e <= end_e + 4'd1;
    end

    // Round counter R: never wraps because the win check comes first.
    always_ff @(posedge clock) begin
        if (!reset || zera_tudo) rodada <= 4'd0;
        else if (avanca_rodada)  rodada <= rodada + 4'd1;
    end

    // Move register: loaded in registra and on the new-move press.
    always_ff @(posedge clock) begin
        if (!reset || zera_tudo) jogada_reg <= '0;
        else if (carrega_jogada) jogada_reg <= botoes;
    end

    // ------------------------------------------------------------------
    // Sequence memory. Address 0 is never written (writes go to R+1), so
    // it is served straight from the power-up image. Addresses above the
    // current round are always written before they can be read.
    // ------------------------------------------------------------------
    // Synchronous write; a reset on the same edge suppresses it.
    always_ff @(posedge clock) begin
        if (reset && escreve_mem) mem[rodada + 4'd1] <= jogada_reg;
    end

    assign mem_dado = (end_e == 4'd0) ? mem_init[0] : mem[end_e];

    assign igual            = (jogada_reg == mem_dado);
    assign end_igual_rodada = (end_e == rodada);
    assign fim_sequencia    = (rodada == ultima_rodada);

    // ------------------------------------------------------------------
    // Optional press timeout.
    // ------------------------------------------------------------------
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
    localparam int tw = $clog2(TIMEOUT_CYCLES + 1);
    logic [tw-1:0] cont_timeout;

    // Timer runs only while waiting for a press and restarts on each press.
    always_ff @(posedge clock) begin
        if (!reset || zera_timeout || jogada) cont_timeout <= '0;
        else if (estado_aguarda(estado))      cont_timeout <= cont_timeout + tw'(1);
    end

    assign timeout    = estado_aguarda(estado) && (cont_timeout == tw'(TIMEOUT_CYCLES - 1));
    assign db_timeout = (estado == st_fim_timeout);
`else
    // Without the timer the limit has no effect on the build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) && zera_timeout;
    assign timeout            = 1'b0;
    assign db_timeout         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM.
    // ------------------------------------------------------------------
    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) estado <= st_inicial;
        else        estado <= proximo_estado;
    end

    // Next-state logic.
    always_comb begin
        proximo_estado = estado;
        case (estado)
            st_inicial:        if (iniciar) proximo_estado = st_preparacao;
            st_preparacao:     proximo_estado = st_espera;
            st_espera: begin
                if (jogada)       proximo_estado = st_registra;
                else if (timeout) proximo_estado = st_fim_timeout;
            end
            st_registra:       proximo_estado = st_compara;
            st_compara: begin
                if (!igual)                 proximo_estado = st_fim_perdeu;
                else if (!end_igual_rodada) proximo_estado = st_proximo;
                else if (fim_sequencia)     proximo_estado = st_fim_ganhou;
                else                        proximo_estado = st_espera_nova;
            end
            st_proximo:        proximo_estado = st_espera;
            st_espera_nova: begin
                if (jogada)       proximo_estado = st_escreve;
                else if (timeout) proximo_estado = st_fim_timeout;
            end
            st_escreve:        proximo_estado = st_proxima_rodada;
            st_proxima_rodada: proximo_estado = st_espera;
            st_fim_ganhou,
            st_fim_perdeu,
            st_fim_timeout:    if (iniciar) proximo_estado = st_preparacao;
            default:           proximo_estado = st_inicial;
        endcase
    end

    // Output and datapath-control decode.
    always_comb begin
        zera_tudo      = 1'b0;
        conta_e        = 1'b0;
        avanca_rodada  = 1'b0;
        carrega_jogada = 1'b0;
        escreve_mem    = 1'b0;
        zera_timeout   = 1'b0;
        pronto         = estado_final(estado);
        ganhou         = (estado == st_fim_ganhou);
        perdeu         = (estado == st_fim_perdeu) || (estado == st_fim_timeout);
        case (estado)
            st_preparacao: begin
                zera_tudo    = 1'b1;
                zera_timeout = 1'b1;
            end
            st_registra:       carrega_jogada = 1'b1;
            st_proximo:        conta_e        = 1'b1;
            st_espera_nova:    carrega_jogada = jogada;
            st_escreve:        escreve_mem    = 1'b1;
            st_proxima_rodada: begin
                avanca_rodada = 1'b1;
                zera_timeout  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and debug displays. In the idle state the comparison and
    // memory views are blanked so the whole board reads zero.
    // ------------------------------------------------------------------
    assign ativo                  = (estado != st_inicial);
    assign leds                   = jogada_reg;
    assign db_clock               = clock;
    assign db_tem_jogada          = tem_jogada;
    assign db_igual               = ativo && igual;
    assign db_enderecoIgualRodada = ativo && end_igual_rodada;

    word_t memoria_visivel;
    assign memoria_visivel = ativo ? mem_dado : '0;

    circuito_exp6_desafio_hexa7seg u_hex_contagem (.valor(end_e),           .segmentos(db_contagem));
    circuito_exp6_desafio_hexa7seg u_hex_memoria  (.valor(memoria_visivel), .segmentos(db_memoria));
    circuito_exp6_desafio_hexa7seg u_hex_jogada   (.valor(jogada_reg),      .segmentos(db_jogadafeita));
    circuito_exp6_desafio_hexa7seg u_hex_rodada   (.valor(rodada),          .segmentos(db_rodada));
    circuito_exp6_desafio_hexa7seg u_hex_estado   (.valor(estado),          .segmentos(db_estado));

endmodule

// File: tb/tb_circuito_exp6_desafio.sv
// Directed bench for circuito_exp6_desafio. Two instances share the same
// stimulus: "a" uses the default 16 rounds, "b" wins after 2 rounds.
module tb_circuito_exp6_desafio;

    localparam int to_cycles = 40;

    // Clock and shared inputs
    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] botoes;

    always #5 clock = ~clock;

    // Instance a outputs
    logic [3:0] a_leds;
    logic       a_pronto, a_ganhou, a_perdeu, a_db_clock, a_db_tem_jogada;
    logic       a_db_igual, a_db_eq, a_db_timeout;
    logic [6:0] a_db_contagem, a_db_memoria, a_db_jogadafeita, a_db_rodada, a_db_estado;

    // Instance b outputs
    logic [3:0] b_leds;
    logic       b_pronto, b_ganhou, b_perdeu, b_db_clock, b_db_tem_jogada;
    logic       b_db_igual, b_db_eq, b_db_timeout;
    logic [6:0] b_db_contagem, b_db_memoria, b_db_jogadafeita, b_db_rodada, b_db_estado;

    circuito_exp6_desafio #(.TIMEOUT_CYCLES(to_cycles)) dut_a (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .leds(a_leds), .pronto(a_pronto), .ganhou(a_ganhou), .perdeu(a_perdeu),
        .db_clock(a_db_clock), .db_tem_jogada(a_db_tem_jogada), .db_igual(a_db_igual),
        .db_enderecoIgualRodada(a_db_eq), .db_timeout(a_db_timeout),
        .db_contagem(a_db_contagem), .db_memoria(a_db_memoria),
        .db_jogadafeita(a_db_jogadafeita), .db_rodada(a_db_rodada), .db_estado(a_db_estado)
    );

    circuito_exp6_desafio #(.TIMEOUT_CYCLES(to_cycles), .N_ROUNDS(2)) dut_b (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .leds(b_leds), .pronto(b_pronto), .ganhou(b_ganhou), .perdeu(b_perdeu),
        .db_clock(b_db_clock), .db_tem_jogada(b_db_tem_jogada), .db_igual(b_db_igual),
        .db_enderecoIgualRodada(b_db_eq), .db_timeout(b_db_timeout),
        .db_contagem(b_db_contagem), .db_memoria(b_db_memoria),
        .db_jogadafeita(b_db_jogadafeita), .db_rodada(b_db_rodada), .db_estado(b_db_estado)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h4: return 7'h19;
            4'h6: return 7'h02;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Hold a move for five cycles, then release for two.
    task automatic press(input logic [3:0] v);
        botoes = v;
        cyc(5);
        botoes = 4'b0000;
        cyc(2);
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        botoes  = 4'b0000;
        cyc(2);

        // Reset state: everything zero, displays show 0
        chk("rst_estado",   a_db_estado,      seg(4'h0));
        chk("rst_pronto",   a_pronto,         0);
        chk("rst_ganhou",   a_ganhou,         0);
        chk("rst_perdeu",   a_perdeu,         0);
        chk("rst_leds",     a_leds,           0);
        chk("rst_igual",    a_db_igual,       0);
        chk("rst_eq",       a_db_eq,          0);
        chk("rst_memoria",  a_db_memoria,     seg(4'h0));
        chk("rst_contagem", a_db_contagem,    seg(4'h0));
        chk("rst_jogada",   a_db_jogadafeita, seg(4'h0));

        // Start held for 10 cycles reaches espera
        reset   = 1'b1;
        iniciar = 1'b1;
        cyc(10);
        iniciar = 1'b0;
        chk("start_estado", a_db_estado, seg(4'h2));
        chk("start_pronto", a_pronto,    0);
        chk("start_rodada", a_db_rodada, seg(4'h0));
        chk("start_mem0",   a_db_memoria, seg(4'h1));

        // Round 1: correct move 0001 -> awaiting new move
        press(4'b0001);
        chk("r1_igual",  a_db_igual,  1);
        chk("r1_estado", a_db_estado, seg(4'h6));
        chk("r1_eq",     a_db_eq,     1);
        chk("r1_leds",   a_leds,      4'b0001);

        // New move 0100 written to mem[1], R=1
        press(4'b0100);
        chk("nova_estado", a_db_estado,      seg(4'h2));
        chk("nova_rodada", a_db_rodada,      seg(4'h1));
        chk("nova_jogada", a_db_jogadafeita, seg(4'h4));
        chk("nova_eq",     a_db_eq,          0);

        // Round 2: first move correct, E advances to show mem[1]
        press(4'b0001);
        chk("r2a_estado",   a_db_estado,   seg(4'h2));
        chk("r2a_contagem", a_db_contagem, seg(4'h1));
        chk("r2a_memoria",  a_db_memoria,  seg(4'h4));

        // Wrong second move 0010 -> lost
        press(4'b0010);
        chk("perde_estado", a_db_estado, seg(4'hD));
        chk("perde_perdeu", a_perdeu,    1);
        chk("perde_pronto", a_pronto,    1);
        chk("perde_ganhou", a_ganhou,    0);
        chk("perde_leds",   a_leds,      4'b0010);
        chk("perde_b",      b_db_estado, seg(4'hD));

        // Restart from the final state
        iniciar = 1'b1;
        cyc(1);
        chk("restart_estado", a_db_estado, seg(4'h1));
        chk("restart_perdeu", a_perdeu,    0);
        cyc(1);
        iniciar = 1'b0;
        chk("restart_leds",   a_leds,      0);

        // Second game: round 2 completed correctly
        press(4'b0001);
        press(4'b0100);
        press(4'b0001);
        press(4'b0100);
        chk("g2_a_estado", a_db_estado, seg(4'h6));
        chk("g2_a_rodada", a_db_rodada, seg(4'h1));
        chk("g2_a_pronto", a_pronto,    0);
        chk("g2_b_estado", b_db_estado, seg(4'hC));
        chk("g2_b_ganhou", b_ganhou,    1);
        chk("g2_b_pronto", b_pronto,    1);
        chk("g2_b_perdeu", b_perdeu,    0);

        // Start is ignored mid-game, honoured in the final state
        iniciar = 1'b1;
        cyc(1);
        chk("ign_a_estado", a_db_estado, seg(4'h6));
        chk("win_b_estado", b_db_estado, seg(4'h1));
        chk("win_b_ganhou", b_ganhou,    0);
        chk("win_b_pronto", b_pronto,    0);
        cyc(1);
        iniciar = 1'b0;

        // Reset while in compara
        reset = 1'b0;
        cyc(1);
        reset   = 1'b1;
        iniciar = 1'b1;
        cyc(2);
        iniciar = 1'b0;
        chk("rc_estado",  a_db_estado,  seg(4'h2));
        chk("rc_mem0",    a_db_memoria, seg(4'h1));
        botoes = 4'b0001;
        cyc(2);
        chk("rc_compara", a_db_estado,     seg(4'h4));
        chk("rc_tem",     a_db_tem_jogada, 1);
        reset = 1'b0;
        cyc(1);
        chk("rc_rst_estado", a_db_estado,      seg(4'h0));
        chk("rc_rst_leds",   a_leds,           0);
        chk("rc_rst_pronto", a_pronto,         0);
        chk("rc_rst_igual",  a_db_igual,       0);
        chk("rc_rst_jogada", a_db_jogadafeita, seg(4'h0));
        botoes = 4'b0000;
        reset  = 1'b1;
        cyc(1);

        // Memory retained after reset: play into round 2 again
        iniciar = 1'b1;
        cyc(2);
        iniciar = 1'b0;
        press(4'b0001);
        chk("ret_igual",  a_db_igual,  1);
        chk("ret_estado", a_db_estado, seg(4'h6));
        press(4'b0100);
        press(4'b0001);
        chk("ret_memoria", a_db_memoria, seg(4'h4));

        // Idle in espera: just below the limit nothing happens
        cyc(to_cycles - 10);
        chk("to_antes", a_db_estado, seg(4'h2));
        cyc(15);
`ifdef CIRCUITO_EXP6_TIMEOUT_EN
        chk("to_estado",  a_db_estado,  seg(4'hE));
        chk("to_flag",    a_db_timeout, 1);
        chk("to_perdeu",  a_perdeu,     1);
        chk("to_pronto",  a_pronto,     1);
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        chk("to_restart", a_db_estado,  seg(4'h1));
        chk("to_clear",   a_db_timeout, 0);
`else
        chk("noto_estado", a_db_estado,  seg(4'h2));
        chk("noto_flag",   a_db_timeout, 0);
        chk("noto_pronto", a_pronto,     0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
